// File: rtl/inv_key_schedule.sv
// Iterative AES-128 inverse key schedule: turns the round-10 key into round keys 10..0.
// Latency: a key accepted on edge N shows round 10 on rk_o in cycle N+1, then one key per accepted beat.
// Backpressure: rk_o, rk_round_o and rk_last_o hold while rk_ready_i is low. A key is accepted only in IDLE.
//
// Ports:
//   clk_i, rst_i              rising-edge clock, asynchronous active-high reset
//   key_valid_i/key_ready_o   key_i handshake (ready only while idle)
//   key_i                     round-10 key (cipher key when INVKS_FWD_PRECOMPUTE_EN); word0 = [127:96]
//   rk_valid_o/rk_ready_i     round key handshake
//   rk_o, rk_round_o          current round key {w0,w1,w2,w3} and its round index (10 down to 0)
//   rk_last_o                 high with rk_valid_o on round 0
//   busy_o                    high whenever not idle
// Optional build macro: INVKS_FWD_PRECOMPUTE_EN. It accepts the cipher key and first runs the
// forward schedule for 10 cycles (EXPAND) to reach round 10. It shares the single SubWord ROM.
module inv_key_schedule #(
    parameter int KEY_W = 128,
    parameter int NR    = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             key_valid_i,
    output logic             key_ready_o,
    input  logic [KEY_W-1:0] key_i,
    output logic             rk_valid_o,
    input  logic             rk_ready_i,
    output logic [KEY_W-1:0] rk_o,
    output logic [3:0]       rk_round_o,
    output logic             rk_last_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_EMIT   = 2'd2
    } state_t;

    localparam logic [3:0] LP_NR = 4'(NR);

    // Forward S-box. Entry 0 sits in the top byte, so byte x lives at bit offset {~x, 3'b000}.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t             r_state;
    logic [KEY_W-1:0]   r_key;
    logic [3:0]         r_rnd;

    logic [31:0] w_a, w_b, w_c, w_d;
    logic [31:0] w_sub_in, w_rot, w_sub, w_rc_word;
    logic [3:0]  w_rc_idx;
    logic [KEY_W-1:0] w_inv_key;

    assign w_a = r_key[127:96];
    assign w_b = r_key[95:64];
    assign w_c = r_key[63:32];
    assign w_d = r_key[31:0];

`ifdef INVKS_FWD_PRECOMPUTE_EN
    logic             w_is_fwd;
    logic [31:0]      w_fa, w_fb, w_fc;
    logic [KEY_W-1:0] w_fwd_key;

    // A single SubWord serves both directions. The forward step rotates d, the inverse step rotates d^c.
    assign w_is_fwd = (r_state == S_EXPAND);
    assign w_sub_in = w_is_fwd ? w_d : (w_d ^ w_c);
    assign w_rc_idx = w_is_fwd ? (r_rnd + 4'd1) : r_rnd;

    assign w_fa      = w_a ^ w_sub ^ w_rc_word;
    assign w_fb      = w_b ^ w_fa;
    assign w_fc      = w_c ^ w_fb;
    assign w_fwd_key = {w_fa, w_fb, w_fc, w_d ^ w_fc};
`else
    // The inverse step first recovers the previous round's w3 (d^c), then feeds it to SubWord.
    assign w_sub_in = w_d ^ w_c;
    assign w_rc_idx = r_rnd;
`endif

    assign w_rot     = {w_sub_in[23:0], w_sub_in[31:24]};
    assign w_sub     = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
    assign w_rc_word = {rcon(w_rc_idx), 24'h0};
    assign w_inv_key = {w_a ^ w_sub ^ w_rc_word, w_b ^ w_a, w_c ^ w_b, w_d ^ w_c};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_key   <= '0;
            r_rnd   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (key_valid_i) begin
                        r_key <= key_i;
`ifdef INVKS_FWD_PRECOMPUTE_EN
                        r_rnd   <= 4'd0;
                        r_state <= S_EXPAND;
`else
                        r_rnd   <= LP_NR;
                        r_state <= S_EMIT;
`endif
                    end
                end
`ifdef INVKS_FWD_PRECOMPUTE_EN
                S_EXPAND: begin
                    r_key <= w_fwd_key;
                    r_rnd <= r_rnd + 4'd1;
                    if (r_rnd == LP_NR - 4'd1) begin
                        r_state <= S_EMIT;
                    end
                end
`endif
                S_EMIT: begin
                    if (rk_ready_i) begin
                        // Round 0 leaves without stepping, so rnd never wraps.
                        if (r_rnd == 4'd0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_key <= w_inv_key;
                            r_rnd <= r_rnd - 4'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs are decodes of registered state, so they follow an asynchronous reset without a clock edge.
    assign key_ready_o = (r_state == S_IDLE);
    assign busy_o      = (r_state != S_IDLE);
    assign rk_valid_o  = (r_state == S_EMIT);
    assign rk_last_o   = (r_state == S_EMIT) && (r_rnd == 4'd0);
    assign rk_o        = r_key;
    assign rk_round_o  = r_rnd;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed testbench for inv_key_schedule using FIPS-197 key expansion vectors.
// Inputs are driven just after the falling edge, and outputs are sampled on the falling edge.
// Backpressure is exercised with a pseudo-random rk_ready_i pattern with forced stalls.
module tb_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         busy;

    int errors = 0;
    int checks = 0;

    logic [127:0] exp_rk [0:10];
    localparam logic [127:0] K_CIPHER = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] Z_ROUND10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] Z_ROUND1  = 128'h62636363626363636263636362636363;

    always #5 clk = ~clk;

    inv_key_schedule #(.KEY_W(128), .NR(10)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .key_valid_i (key_valid),
        .key_ready_o (key_ready),
        .key_i       (key),
        .rk_valid_o  (rk_valid),
        .rk_ready_i  (rk_ready),
        .rk_o        (rk),
        .rk_round_o  (rk_round),
        .rk_last_o   (rk_last),
        .busy_o      (busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge while idle. Returns at the falling edge of the first EMIT cycle.
    task automatic issue_key(input logic [127:0] k10, input logic [127:0] k0);
        key_valid = 1'b1;
`ifdef INVKS_FWD_PRECOMPUTE_EN
        key = k0;
`else
        key = k10;
`endif
        @(negedge clk);
        key_valid = 1'b0;
        key = 128'hdeadbeef_cafef00d_01234567_89abcdef;
`ifdef INVKS_FWD_PRECOMPUTE_EN
        for (int i = 0; i < 10; i++) begin
            chk("expand_busy", 128'(busy), 128'd1);
            chk("expand_valid", 128'(rk_valid), 128'd0);
            @(negedge clk);
        end
`else
        chk("issue_k0_unused", k0 ^ k0, 128'd0);
`endif
    endtask

    initial begin
        exp_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst = 1'b1;
        key_valid = 1'b0;
        key = '0;
        rk_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_key_ready", 128'(key_ready), 128'd1);
        chk("rst_rk_valid", 128'(rk_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_last", 128'(rk_last), 128'd0);
        chk("rst_rk", rk, 128'd0);
        chk("rst_round", 128'(rk_round), 128'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_valid", 128'(rk_valid), 128'd0);

        // T1: full sequence with ready held high
        rk_ready = 1'b1;
        issue_key(exp_rk[10], K_CIPHER);
        for (int i = 0; i <= 10; i++) begin
            chk("t1_valid", 128'(rk_valid), 128'd1);
            chk("t1_round", 128'(rk_round), 128'(10 - i));
            chk("t1_key", rk, exp_rk[10 - i]);
            chk("t1_last", 128'(rk_last), 128'(i == 10));
            chk("t1_key_ready", 128'(key_ready), 128'd0);
            @(negedge clk);
        end
        chk("t1_end_valid", 128'(rk_valid), 128'd0);
        chk("t1_end_ready", 128'(key_ready), 128'd1);
        chk("t1_end_busy", 128'(busy), 128'd0);

        // T2: all-zero cipher key
        issue_key(Z_ROUND10, 128'd0);
        for (int i = 0; i <= 10; i++) begin
            chk("t2_round", 128'(rk_round), 128'(10 - i));
            if (i == 0)  chk("t2_key10", rk, Z_ROUND10);
            if (i == 9)  chk("t2_key1", rk, Z_ROUND1);
            if (i == 10) begin
                chk("t2_key0", rk, 128'd0);
                chk("t2_last", 128'(rk_last), 128'd1);
            end
            @(negedge clk);
        end
        chk("t2_end_valid", 128'(rk_valid), 128'd0);

        // T3: backpressure
        begin
            int idx;
            int cyc;
            idx = 10;
            cyc = 0;
            issue_key(exp_rk[10], K_CIPHER);
            while (idx >= 0 && cyc < 300) begin
                chk("t3_valid", 128'(rk_valid), 128'd1);
                chk("t3_round", 128'(rk_round), 128'(idx));
                chk("t3_key", rk, exp_rk[idx]);
                chk("t3_last", 128'(rk_last), 128'(idx == 0));
                rk_ready = (cyc % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
                if (rk_ready) idx--;
                cyc++;
                @(negedge clk);
            end
            chk("t3_done", 128'(idx < 0), 128'd1);
            chk("t3_end_valid", 128'(rk_valid), 128'd0);
        end

        // T4: second key held during EMIT is taken one cycle after the round-0 accept
        rk_ready = 1'b1;
        issue_key(exp_rk[10], K_CIPHER);
        key_valid = 1'b1;
`ifdef INVKS_FWD_PRECOMPUTE_EN
        key = 128'd0;
`else
        key = Z_ROUND10;
`endif
        for (int i = 0; i <= 10; i++) begin
            chk("t4_key_ready", 128'(key_ready), 128'd0);
            chk("t4_round", 128'(rk_round), 128'(10 - i));
            @(negedge clk);
        end
        chk("t4_bubble_ready", 128'(key_ready), 128'd1);
        chk("t4_bubble_valid", 128'(rk_valid), 128'd0);
        issue_key(Z_ROUND10, 128'd0);
        chk("t4_second_valid", 128'(rk_valid), 128'd1);
        chk("t4_second_key", rk, Z_ROUND10);

        // T5: reset mid-operation at round 6
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("t5_round6", 128'(rk_round), 128'd6);
        rst = 1'b1;
        #1;
        chk("t5_valid", 128'(rk_valid), 128'd0);
        chk("t5_key_ready", 128'(key_ready), 128'd1);
        chk("t5_round", 128'(rk_round), 128'd0);
        chk("t5_rk", rk, 128'd0);
        chk("t5_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_no_valid", 128'(rk_valid), 128'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
